// File: rtl/div_sequencer_if.sv
// EX-stage request/response bundle between M-extension decode and the divide sequencer.
interface div_sequencer_if;
  logic        req_valid;
  logic [2:0]  req_funct3;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic        flush;
  logic        stall;
  logic        result_valid;
  logic [31:0] result;

  modport master (
    output req_valid, req_funct3, req_rs1, req_rs2, flush,
    input  stall, result_valid, result
  );

  modport slave (
    input  req_valid, req_funct3, req_rs1, req_rs2, flush,
    output stall, result_valid, result
  );
endinterface

// File: rtl/div_sequencer.sv
// Sequences one DIV/DIVU/REM/REMU through the iterative divider, answering zero-divisor,
// signed overflow and repeat-operand requests (one-entry result cache) without a divider run.
//   state | meaning
//   IDLE  | waiting for a divide request
//   ISSUE | start pulse to the divider with latched operands
//   BUSY  | divider running, result wanted
//   RESP  | result presented to EX for one cycle
//   DRAIN | divider running for a flushed request, result only fills the cache
module div_sequencer (
  input  logic                 clk,
  input  logic                 rst,
  div_sequencer_if.slave       ex,
  output logic                 div_start,
  output logic [2:0]           div_funct3,
  output logic [31:0]          div_dividend,
  output logic [31:0]          div_divisor,
  input  logic                 div_done,
  input  logic [31:0]          div_quotient,
  input  logic [31:0]          div_remainder
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_BUSY, S_RESP, S_DRAIN} state_e;

  state_e      state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic        sgn_q, sgn_d;
  logic [31:0] quo_q, quo_d, rem_q, rem_d;
  logic        cache_v_q, cache_v_d;
  logic [31:0] c_rs1_q, c_rs1_d, c_rs2_q, c_rs2_d;
  logic        c_sgn_q, c_sgn_d;
  logic [31:0] c_quo_q, c_quo_d, c_rem_q, c_rem_d;

  logic        req_div, req_sgn, zero_div, ovf, hit, cache_wr;
  logic [31:0] rem_fixed;

  // funct3: 100 div, 101 divu, 110 rem, 111 remu
  assign req_div  = ex.req_valid & ex.req_funct3[2];
  assign req_sgn  = ~ex.req_funct3[0];
  assign zero_div = (ex.req_rs2 == 32'd0);
  assign ovf      = req_sgn & (ex.req_rs1 == 32'h8000_0000) & (ex.req_rs2 == 32'hFFFF_FFFF);
  assign hit      = cache_v_q & (c_rs1_q == ex.req_rs1) & (c_rs2_q == ex.req_rs2)
                    & (c_sgn_q == req_sgn);

  // divider hands back a remainder magnitude; it takes the dividend's sign
  assign rem_fixed = (sgn_q & rs1_q[31]) ? (32'd0 - div_remainder) : div_remainder;

  always_comb begin
    state_d   = state_q;
    funct3_d  = funct3_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    sgn_d     = sgn_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    cache_v_d = cache_v_q;
    c_rs1_d   = c_rs1_q;
    c_rs2_d   = c_rs2_q;
    c_sgn_d   = c_sgn_q;
    c_quo_d   = c_quo_q;
    c_rem_d   = c_rem_q;
    cache_wr  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_div && !ex.flush) begin
          funct3_d = ex.req_funct3;
          rs1_d    = ex.req_rs1;
          rs2_d    = ex.req_rs2;
          sgn_d    = req_sgn;
          if (zero_div) begin
            quo_d   = 32'hFFFF_FFFF;
            rem_d   = ex.req_rs1;
            state_d = S_RESP;
          end else if (ovf) begin
            quo_d   = 32'h8000_0000;
            rem_d   = 32'd0;
            state_d = S_RESP;
          end else if (hit) begin
            quo_d   = c_quo_q;
            rem_d   = c_rem_q;
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = ex.flush ? S_IDLE : S_BUSY;
      S_BUSY: begin
        if (div_done) begin
          cache_wr = 1'b1;
          quo_d    = div_quotient;
          rem_d    = rem_fixed;
          state_d  = ex.flush ? S_IDLE : S_RESP;
        end else if (ex.flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (div_done) begin
          cache_wr = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (cache_wr) begin
      cache_v_d = 1'b1;
      c_rs1_d   = rs1_q;
      c_rs2_d   = rs2_q;
      c_sgn_d   = sgn_q;
      c_quo_d   = div_quotient;
      c_rem_d   = rem_fixed;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      funct3_q  <= 3'd0;
      rs1_q     <= 32'd0;
      rs2_q     <= 32'd0;
      sgn_q     <= 1'b0;
      quo_q     <= 32'd0;
      rem_q     <= 32'd0;
      cache_v_q <= 1'b0;
      c_rs1_q   <= 32'd0;
      c_rs2_q   <= 32'd0;
      c_sgn_q   <= 1'b0;
      c_quo_q   <= 32'd0;
      c_rem_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      funct3_q  <= funct3_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      sgn_q     <= sgn_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      cache_v_q <= cache_v_d;
      c_rs1_q   <= c_rs1_d;
      c_rs2_q   <= c_rs2_d;
      c_sgn_q   <= c_sgn_d;
      c_quo_q   <= c_quo_d;
      c_rem_q   <= c_rem_d;
    end
  end

  assign ex.result_valid = (state_q == S_RESP) & ~ex.flush;
  assign ex.result       = ex.result_valid ? (funct3_q[1] ? rem_q : quo_q) : 32'd0;
  assign ex.stall        = req_div & ~ex.result_valid;
  assign div_start       = (state_q == S_ISSUE) & ~ex.flush;
  assign div_funct3      = funct3_q;
  assign div_dividend    = rs1_q;
  assign div_divisor     = rs2_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: RISC-V M-extension reference results, a 33-cycle
// divider model, and a last-divider-run cache model to predict latency and start pulses.
module tb_div_sequencer;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_sequencer_if ex();
  logic        div_start, div_done;
  logic [2:0]  div_funct3;
  logic [31:0] div_dividend, div_divisor, div_quotient, div_remainder;

  div_sequencer dut (
    .clk(clk), .rst(rst), .ex(ex),
    .div_start(div_start), .div_funct3(div_funct3),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          starts;
    int          t_req;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  int          compared = 0, mismatched = 0;
  int          cyc = 0;
  int          starts_seen = 0;
  bit          mon_en = 0;
  logic [2:0]  cur_f3;
  logic [31:0] cur_a, cur_b;
  bit          m_cache_v = 0;
  logic [31:0] m_a, m_b;
  bit          m_sgn;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural result of an M-extension divide/remainder.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (!f3[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    q = sa / sb;
    r = sa - q * sb;
    return f3[1] ? r[31:0] : q[31:0];
  endfunction

  // Divider unit output: sign-corrected quotient, remainder magnitude.
  function automatic logic [63:0] divider_out(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) return {32'hFFFF_FFFF, a};
    if (!f3[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = (sa < 0 ? -sa : sa) % (sb < 0 ? -sb : sb);
    end else begin
      sa = longint'(a);
      sb = longint'(b);
      q  = sa / sb;
      r  = sa % sb;
    end
    return {q[31:0], r[31:0]};
  endfunction

  int          dv_cnt;
  logic        dv_busy;
  logic [63:0] dv_qr;

  always @(posedge clk) begin
    if (rst) begin
      dv_busy <= 1'b0;
      dv_cnt <= 0;
      div_done <= 1'b0;
      div_quotient <= 32'd0;
      div_remainder <= 32'd0;
    end else begin
      div_done <= 1'b0;
      if (div_start && !dv_busy) begin
        dv_busy <= 1'b1;
        dv_cnt <= 32;
        dv_qr <= divider_out(div_funct3, div_dividend, div_divisor);
      end else if (dv_busy) begin
        if (dv_cnt == 1) begin
          div_done <= 1'b1;
          div_quotient <= dv_qr[63:32];
          div_remainder <= dv_qr[31:0];
          dv_busy <= 1'b0;
        end
        dv_cnt <= dv_cnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && !rst) begin
      chk("stall", 32'(ex.stall),
          32'(ex.req_valid & ex.req_funct3[2] & ~ex.result_valid));
      if (div_start) begin
        starts_seen++;
        chk("start_while_divider_busy", 32'(dv_busy), 32'd0);
        chk("div_dividend", div_dividend, cur_a);
        chk("div_divisor", div_divisor, cur_b);
        chk("div_funct3", 32'(div_funct3), 32'(cur_f3));
      end
      if (ex.result_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_result_valid", 32'(ex.result_valid), 32'd0);
        end else begin
          e = sbq.pop_front();
          chk({e.name, "_result"}, ex.result, e.res);
          chk({e.name, "_latency"}, 32'(cyc - e.t_req), 32'(e.lat));
          chk({e.name, "_starts"}, 32'(starts_seen), 32'(e.starts));
          starts_seen = 0;
        end
      end else begin
        chk("result_zero_when_idle", ex.result, 32'd0);
      end
    end
  end

  task automatic drive_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    cur_f3 = f3;
    cur_a = a;
    cur_b = b;
    ex.req_valid = 1'b1;
    ex.req_funct3 = f3;
    ex.req_rs1 = a;
    ex.req_rs2 = b;
  endtask

  task automatic do_req(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b);
    exp_t e;
    bit   sgn, fast, seen;
    sgn  = ~f3[0];
    fast = (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ||
           (m_cache_v && m_a == a && m_b == b && m_sgn == sgn);
    e.res    = ref_result(f3, a, b);
    e.lat    = fast ? 1 : 35;
    e.starts = fast ? 0 : 1;
    e.name   = name;
    if (!fast) begin
      m_cache_v = 1;
      m_a = a;
      m_b = b;
      m_sgn = sgn;
    end
    drive_req(f3, a, b);
    e.t_req = cyc;
    sbq.push_back(e);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (ex.result_valid) seen = 1;
    end
    if (!seen) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
      sbq.delete();
    end
    @(posedge clk);
    #1;
    ex.req_valid = 1'b0;
  endtask

  task automatic wait_start(input string name);
    bit seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (div_start) seen = 1;
    end
    if (!seen) chk({name, "_start_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic nondiv(input logic [1:0] low);
    drive_req({1'b0, low}, $urandom, $urandom);
    repeat (3) @(posedge clk);
    #1;
    ex.req_valid = 1'b0;
  endtask

  initial begin
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] a, b, pa, pb;
    bit          seen;
    int          k;

    rst = 1'b1;
    ex.req_valid = 1'b0;
    ex.req_funct3 = 3'd0;
    ex.req_rs1 = 32'd0;
    ex.req_rs2 = 32'd0;
    ex.flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_result_valid", 32'(ex.result_valid), 32'd0);
    chk("reset_result", ex.result, 32'd0);
    chk("reset_div_start", 32'(div_start), 32'd0);
    chk("reset_stall_low", 32'(ex.stall), 32'd0);
    ex.req_valid = 1'b1;
    ex.req_funct3 = F_DIV;
    #1;
    chk("reset_stall_follows_req", 32'(ex.stall), 32'd1);
    ex.req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1;

    do_req("divu_100_7", F_DIVU, 32'd100, 32'd7);
    do_req("remu_100_7_hit", F_REMU, 32'd100, 32'd7);
    do_req("rem_m7_2", F_REM, 32'hFFFF_FFF9, 32'd2);
    do_req("div_m7_2_hit", F_DIV, 32'hFFFF_FFF9, 32'd2);
    do_req("rem_by_zero", F_REM, 32'd1234, 32'd0);
    do_req("divu_by_zero", F_DIVU, 32'd1234, 32'd0);
    do_req("div_m7_2_still_cached", F_DIV, 32'hFFFF_FFF9, 32'd2);
    do_req("div_overflow", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    do_req("rem_overflow", F_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    do_req("divu_big", F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);

    // Flush ten cycles into a divider run; the drained result still fills the cache.
    drive_req(F_DIV, 32'd1000, 32'd3);
    wait_start("flush_run");
    repeat (10) @(posedge clk);
    #1;
    ex.flush = 1'b1;
    ex.req_valid = 1'b0;
    @(posedge clk);
    #1;
    ex.flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (div_done) seen = 1;
    end
    if (!seen) chk("flush_drain_done_timeout", 32'd0, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("flush_start_count", 32'(starts_seen), 32'd1);
    starts_seen = 0;
    m_cache_v = 1;
    m_a = 32'd1000;
    m_b = 32'd3;
    m_sgn = 1;
    do_req("rem_after_flush_hit", F_REM, 32'd1000, 32'd3);

    // Reset in the middle of a divider run drops the request and the cache.
    drive_req(F_DIVU, 32'd5555, 32'd11);
    wait_start("reset_run");
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    ex.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrun_reset_result_valid", 32'(ex.result_valid), 32'd0);
    chk("midrun_reset_result", ex.result, 32'd0);
    chk("midrun_reset_div_start", 32'(div_start), 32'd0);
    chk("midrun_reset_stall", 32'(ex.stall), 32'd0);
    chk("midrun_reset_dividend", div_dividend, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    starts_seen = 0;
    m_cache_v = 0;
    do_req("divu_after_reset", F_DIVU, 32'd5555, 32'd11);

    pa = 32'd5555;
    pb = 32'd11;
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 9);
      lo = 2'($urandom_range(0, 3));
      f3 = {1'b1, lo};
      a = $urandom;
      b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 300)) : $urandom;
      case (k)
        0: b = 32'd0;
        1: begin
          f3 = ($urandom_range(0, 1) == 1) ? F_DIV : F_REM;
          a = 32'h8000_0000;
          b = 32'hFFFF_FFFF;
        end
        2, 3, 4: begin
          a = pa;
          b = pb;
        end
        default: ;
      endcase
      if (k == 5) begin
        nondiv(lo);
      end else begin
        do_req("random", f3, a, b);
        pa = a;
        pb = b;
      end
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/div_sequencer.md
# div_sequencer

Controller between the EX-stage M-extension decode and the iterative `divider` unit. It accepts one divide/remainder request at a time and stalls the pipeline until the result is returned. Divide-by-zero and signed overflow are answered in one cycle without starting the divider. A one-entry result cache lets a DIV/REM pair on the same operands finish without a second 32-iteration run. It also fixes the remainder sign for signed REM and drains a divider run that a pipeline flush has killed.

## Interface
- Parameters: none.
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  EX-stage request; held stable with its operands until result_valid
- req_funct3  in  m_funct3  div/divu/rem/remu; other codes are ignored (no stall, no action)
- req_rs1  in  32  dividend
- req_rs2  in  32  divisor
- flush  in  1  pipeline kill of the current request
- stall  out  1  = req_valid & is_div(req_funct3) & ~result_valid (combinational)
- result_valid  out  1  result present this cycle
- result  out  32  quotient (div/divu) or remainder (rem/remu); 0 when result_valid=0
- div_start  out  1  one-cycle start pulse to divider
- div_funct3  out  m_funct3  latched funct3
- div_dividend  out  32  latched rs1
- div_divisor  out  32  latched rs2
- div_done  in  1  divider completion (one cycle)
- div_quotient  in  32  sign-corrected quotient, valid with div_done
- div_remainder  in  32  remainder magnitude for signed ops, valid with div_done

## Operation
- States: IDLE, ISSUE, BUSY, RESP, DRAIN.
- IDLE, div request, no flush:
  - latch funct3, rs1, rs2 and sgn = (div|rem); go to RESP or ISSUE as classified below.
- Request classification, in priority order:
  - rs2==0: quotient=FFFFFFFF, remainder=rs1; go to RESP.
  - sgn & rs1==80000000 & rs2==FFFFFFFF: quotient=80000000, remainder=0; go to RESP.
  - Cache hit (valid & rs1, rs2, sgn all match): cached quotient/remainder; go to RESP.
  - Otherwise: go to ISSUE.
- ISSUE:
  - div_start=1 with the latched operands; go to BUSY.
- BUSY: wait for div_done.
  - On div_done: capture quotient and remainder. If sgn & rs1[31], remainder = -div_remainder (two's complement); else remainder = div_remainder.
  - Write the captured values into the cache (valid=1, tags rs1/rs2/sgn) and go to RESP.
- RESP:
  - result_valid = ~flush; result = quotient for div/divu, remainder for rem/remu.
  - Always go to IDLE next.
  - A request presented in the RESP cycle is the one being completed and is not re-accepted.
- Flush handling:
  - IDLE: request ignored.
  - ISSUE: go to IDLE, no start.
  - BUSY: go to DRAIN.
  - DRAIN: wait for div_done, write the cache as in BUSY, produce no result, go to IDLE. Flush is ignored while in DRAIN.
  - flush and div_done in the same BUSY cycle: write the cache, go to IDLE, no result.
- Special-case results (zero divisor, overflow) never write the cache.
- Only one divider run is outstanding at a time. div_start is never asserted outside ISSUE.

## Timing
- Reset: state=IDLE, cache valid=0, result register=0, div_start=0, result_valid=0, result=0. stall follows req_valid combinationally.
- Reset mid-run: the controller returns to IDLE. The divider shares rst, so no drain is needed.
- Fast path (zero divisor, overflow, cache hit):
  - request seen in IDLE at cycle t; result_valid at t+1.
  - stall high for t only.
- Divider path:
  - ISSUE at t+1 (div_start).
  - div_done at t+34, with the divider taking 33 cycles from start to done.
  - result_valid at t+35; stall high for t..t+34.
  - The controller waits on div_done only and does not count cycles.
- Back-to-back: the next request can be accepted at t+2 (fast path) or t+36 (divider path).
- Outputs: result_valid and result are registered-state driven; div_* operand outputs are registers.

## Test plan
- divu 100/7: div_start at t+1 with operands 100 and 7; result 14 at t+35. Then remu 100/7: fast hit, result 2 at t+1.
- rem −7/2, i.e. rs1=FFFFFFF9, rs2=2: result FFFFFFFF. Then div on the same operands hits the cache: result FFFFFFFD, no div_start.
- div by zero, rs1=1234 (rem): result 1234 one cycle after the request, no div_start, cache unchanged. divu by zero: result FFFFFFFF.
- div 80000000/FFFFFFFF: result 80000000 at t+1. rem on the same operands: result 0. divu on the same operands: takes the divider path, result 0.
- flush 10 cycles after ISSUE: no result_valid. div_start is not reasserted until div_done has been seen. A new request for the same operands then hits the cache.
- Assert rst mid-BUSY: all outputs 0 the next cycle. The cache is invalidated, so a repeated request takes the divider path.
